// File: rtl/demux4_result_bank.sv
// ---------------------------------------------------------------------------
// demux4_result_bank
//
// Steers one result bus into one of four registered destination slots. Each
// slot keeps its value until its consumer acknowledges it. The block also
// tracks how many slots are occupied and keeps a sticky overflow flag.
//
// Input handshake (valid/ready):
//   - A write transfers on a rising edge when in_valid && in_ready.
//   - in_ready depends only on in_sel, q_valid and q_ack. It never depends
//     on in_valid, so a source may safely wait on it.
//   - While in_valid is high and in_ready is low, the source must hold
//     in_data and in_sel stable. The block does not check this.
//   - A consumer takes slot i on any edge where q_ack[i] && q_valid[i].
//     An ack on an empty slot is ignored.
//
// Ports:
//   clk        - single clock; all state updates on the rising edge
//   reset      - synchronous, active-high; overrides every other input
//   in_data    - result to store; bit WIDTH-1 is the overflow bit
//   in_sel     - destination slot index 0..3
//   in_valid   - in_data/in_sel are valid this cycle
//   in_ready   - the selected slot can accept this cycle (combinational)
//   q0..q3     - stored slot values; held after consume, never zeroed
//   q_valid    - bit i set = slot i holds unconsumed data
//   q_ack      - bit i set = consumer of slot i takes its data this cycle
//   occupancy  - number of set bits in q_valid (0..4), registered
//   ovf_flag   - sticky: set by an accepted write with in_data[WIDTH-1] = 1
//   ovf_clr    - clears ovf_flag; a same-cycle set takes priority
// ---------------------------------------------------------------------------
module demux4_result_bank #(
    parameter int WIDTH = 11
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic [1:0]       in_sel,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] q0,
    output logic [WIDTH-1:0] q1,
    output logic [WIDTH-1:0] q2,
    output logic [WIDTH-1:0] q3,
    output logic [3:0]       q_valid,
    input  logic [3:0]       q_ack,
    output logic [2:0]       occupancy,
    output logic             ovf_flag,
    input  logic             ovf_clr
);

    logic [WIDTH-1:0] data_q [4];
    logic [WIDTH-1:0] data_d [4];
    logic [3:0]       valid_q, valid_d;
    logic [2:0]       occ_q, occ_d;
    logic             ovf_q, ovf_d;

    logic             accept;
    logic [3:0]       we;
    logic [3:0]       ack_eff;

    function automatic logic [2:0] popcount4(input logic [3:0] v);
        return {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
    endfunction

    // An ack on the selected slot frees it in the same cycle, so a full
    // slot can be refilled back-to-back (write-through).
    assign in_ready = ~valid_q[in_sel] | q_ack[in_sel];
    assign accept   = in_valid & in_ready;

    // Only acks against occupied slots have any effect.
    assign ack_eff  = q_ack & valid_q;

    // 2-to-4 write-enable decoder, gated by accept.
    always_comb begin
        we = 4'b0000;
        if (accept) begin
            we[in_sel] = 1'b1;
        end
    end

    // A write sets valid after the ack clear, so an ack and a write to the
    // same slot on one cycle leave the slot valid with the new data.
    always_comb begin
        valid_d = (valid_q & ~ack_eff) | we;
        occ_d   = popcount4(valid_d);
        ovf_d   = (accept & in_data[WIDTH-1]) | (ovf_q & ~ovf_clr);
        for (int i = 0; i < 4; i++) begin
            data_d[i] = we[i] ? in_data : data_q[i];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 4'b0000;
            occ_q   <= 3'd0;
            ovf_q   <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            occ_q   <= occ_d;
            ovf_q   <= ovf_d;
            for (int i = 0; i < 4; i++) begin
                data_q[i] <= data_d[i];
            end
        end
    end

    assign q0        = data_q[0];
    assign q1        = data_q[1];
    assign q2        = data_q[2];
    assign q3        = data_q[3];
    assign q_valid   = valid_q;
    assign occupancy = occ_q;
    assign ovf_flag  = ovf_q;

endmodule

// File: tb/tb_demux4_result_bank.sv
module tb_demux4_result_bank;

    localparam int W = 11;

    // ---------------- clock / reset ----------------
    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] in_data;
    logic [1:0]   in_sel;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] q0, q1, q2, q3;
    logic [3:0]   q_valid;
    logic [3:0]   q_ack;
    logic [2:0]   occupancy;
    logic         ovf_flag;
    logic         ovf_clr;

    always #5 clk = ~clk;

    demux4_result_bank #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .q0        (q0),
        .q1        (q1),
        .q2        (q2),
        .q3        (q3),
        .q_valid   (q_valid),
        .q_ack     (q_ack),
        .occupancy (occupancy),
        .ovf_flag  (ovf_flag),
        .ovf_clr   (ovf_clr)
    );

    // ---------------- scoreboard counters ----------------
    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic         rst;
        logic [W-1:0] d;
        logic [1:0]   sel;
        logic         vld;
        logic [3:0]   ack;
        logic         clr;
        logic         chk_rdy;
        logic         rdy;
        logic [W-1:0] e0, e1, e2, e3;
        logic [3:0]   ev;
        logic [2:0]   eocc;
        logic         eovf;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(
        input logic rst, input logic [W-1:0] d, input logic [1:0] sel,
        input logic vld, input logic [3:0] ack, input logic clr,
        input logic chk_rdy, input logic rdy,
        input logic [W-1:0] e0, input logic [W-1:0] e1,
        input logic [W-1:0] e2, input logic [W-1:0] e3,
        input logic [3:0] ev, input logic [2:0] eocc, input logic eovf);
        vec_t v;
        v.rst = rst; v.d = d; v.sel = sel; v.vld = vld; v.ack = ack; v.clr = clr;
        v.chk_rdy = chk_rdy; v.rdy = rdy;
        v.e0 = e0; v.e1 = e1; v.e2 = e2; v.e3 = e3;
        v.ev = ev; v.eocc = eocc; v.eovf = eovf;
        return v;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic drive(input logic rst, input logic [W-1:0] d, input logic [1:0] sel,
                         input logic vld, input logic [3:0] ack, input logic clr);
        @(negedge clk);
        reset    = rst;
        in_data  = d;
        in_sel   = sel;
        in_valid = vld;
        q_ack    = ack;
        ovf_clr  = clr;
    endtask

    task automatic check_state(input string tag, input logic [W-1:0] e0, input logic [W-1:0] e1,
                               input logic [W-1:0] e2, input logic [W-1:0] e3,
                               input logic [3:0] ev, input logic [2:0] eocc, input logic eovf);
        check({tag, ".q0"},        32'(q0),        32'(e0));
        check({tag, ".q1"},        32'(q1),        32'(e1));
        check({tag, ".q2"},        32'(q2),        32'(e2));
        check({tag, ".q3"},        32'(q3),        32'(e3));
        check({tag, ".q_valid"},   32'(q_valid),   32'(ev));
        check({tag, ".occupancy"}, 32'(occupancy), 32'(eocc));
        check({tag, ".ovf_flag"},  32'(ovf_flag),  32'(eovf));
    endtask

    initial begin
        reset = 1'b1; in_data = '0; in_sel = 2'd0; in_valid = 1'b0;
        q_ack = 4'b0000; ovf_clr = 1'b0;

        // Reset, then idle: in_ready high for every select
        vecs.push_back(mk(1, 'h000, 0, 0, 4'b0000, 0, 0, 0, 'h000, 'h000, 'h000, 'h000, 4'b0000, 0, 0));
        for (int s = 0; s < 4; s++)
            vecs.push_back(mk(0, 'h000, 2'(s), 0, 4'b0000, 0, 1, 1, 'h000, 'h000, 'h000, 'h000, 4'b0000, 0, 0));
        // Two back-to-back writes
        vecs.push_back(mk(0, 'h005, 2, 1, 4'b0000, 0, 1, 1, 'h000, 'h000, 'h005, 'h000, 4'b0100, 1, 0));
        vecs.push_back(mk(0, 'h3FF, 0, 1, 4'b0000, 0, 1, 1, 'h3FF, 'h000, 'h005, 'h000, 4'b0101, 2, 0));
        // Full slot blocks; ack on the same slot lets write-through happen
        vecs.push_back(mk(0, 'h123, 2, 1, 4'b0000, 0, 1, 0, 'h3FF, 'h000, 'h005, 'h000, 4'b0101, 2, 0));
        vecs.push_back(mk(0, 'h123, 2, 1, 4'b0100, 0, 1, 1, 'h3FF, 'h000, 'h123, 'h000, 4'b0101, 2, 0));
        // Ack all: valid clears, data held
        vecs.push_back(mk(0, 'h000, 0, 0, 4'b1111, 0, 1, 1, 'h3FF, 'h000, 'h123, 'h000, 4'b0000, 0, 0));
        // Overflow set beats clear; clear alone; rejected write cannot set
        vecs.push_back(mk(0, 'h400, 1, 1, 4'b0000, 1, 1, 1, 'h3FF, 'h400, 'h123, 'h000, 4'b0010, 1, 1));
        vecs.push_back(mk(0, 'h000, 1, 0, 4'b0000, 1, 1, 0, 'h3FF, 'h400, 'h123, 'h000, 4'b0010, 1, 0));
        vecs.push_back(mk(0, 'h7FF, 1, 1, 4'b0000, 0, 1, 0, 'h3FF, 'h400, 'h123, 'h000, 4'b0010, 1, 0));
        // Ack slot 1 while writing slot 3
        vecs.push_back(mk(0, 'h0AA, 3, 1, 4'b0010, 0, 1, 1, 'h3FF, 'h400, 'h123, 'h0AA, 4'b1000, 1, 0));
        // Ack on an empty slot is ignored
        vecs.push_back(mk(0, 'h000, 0, 0, 4'b0001, 0, 1, 1, 'h3FF, 'h400, 'h123, 'h0AA, 4'b1000, 1, 0));
        // Fill to 4
        vecs.push_back(mk(0, 'h111, 0, 1, 4'b0000, 0, 1, 1, 'h111, 'h400, 'h123, 'h0AA, 4'b1001, 2, 0));
        vecs.push_back(mk(0, 'h222, 2, 1, 4'b0000, 0, 1, 1, 'h111, 'h400, 'h222, 'h0AA, 4'b1101, 3, 0));
        vecs.push_back(mk(0, 'h333, 1, 1, 4'b0000, 0, 1, 1, 'h111, 'h333, 'h222, 'h0AA, 4'b1111, 4, 0));
        // Partial ack leaves two full slots
        vecs.push_back(mk(0, 'h000, 0, 0, 4'b1001, 0, 1, 1, 'h111, 'h333, 'h222, 'h0AA, 4'b0110, 2, 0));
        // Reset during an accepted write (with overflow bit) wipes everything
        vecs.push_back(mk(1, 'h7FF, 3, 1, 4'b0000, 0, 1, 1, 'h000, 'h000, 'h000, 'h000, 4'b0000, 0, 0));
        vecs.push_back(mk(0, 'h000, 2, 0, 4'b0000, 0, 1, 1, 'h000, 'h000, 'h000, 'h000, 4'b0000, 0, 0));

        foreach (vecs[i]) begin
            string tag;
            tag = $sformatf("v%0d", i);
            drive(vecs[i].rst, vecs[i].d, vecs[i].sel, vecs[i].vld, vecs[i].ack, vecs[i].clr);
            #1;
            if (vecs[i].chk_rdy)
                check({tag, ".in_ready"}, 32'(in_ready), 32'(vecs[i].rdy));
            @(posedge clk);
            #1;
            check_state(tag, vecs[i].e0, vecs[i].e1, vecs[i].e2, vecs[i].e3,
                        vecs[i].ev, vecs[i].eocc, vecs[i].eovf);
        end

        // Hand sequence: one-cycle latency, then write-through with overflow
        drive(0, 'h401, 0, 1, 4'b0000, 0);
        #1;
        check("h1.in_ready", 32'(in_ready), 32'd1);
        check("h1.q0_before_edge", 32'(q0), 32'h000);
        check("h1.q_valid_before_edge", 32'(q_valid), 32'h0);
        @(posedge clk); #1;
        check_state("h1", 'h401, 'h000, 'h000, 'h000, 4'b0001, 1, 1);

        drive(0, 'h402, 0, 1, 4'b0001, 1);
        #1;
        check("h2.in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        check_state("h2", 'h402, 'h000, 'h000, 'h000, 4'b0001, 1, 1);

        drive(0, 'h000, 0, 0, 4'b0000, 1);
        @(posedge clk); #1;
        check_state("h3", 'h402, 'h000, 'h000, 'h000, 4'b0001, 1, 0);

        // Hand sequence: ack slot 0 and write slot 3 with the same cycle
        drive(0, 'h0F0, 3, 1, 4'b0001, 0);
        #1;
        check("h4.in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        check_state("h4", 'h402, 'h000, 'h000, 'h0F0, 4'b1000, 1, 0);

        drive(0, 'h000, 0, 0, 4'b0000, 0);
        @(posedge clk); #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
